// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: multi-channel HDMI TMDS encoder covering video (8b/10b
// with DC balance), control, video/data-island guard bands and TERC4 symbols.
// Two-stage pipeline, shared clock enable; channel k takes guard-band role k%3.
// Ports:
//   clkin      - pixel clock
//   rstin      - asynchronous active-high reset
//   ce         - clock enable; all pipeline state holds while low
//   mode       - period type (0 ctrl, 1 video, 2 video GB, 3 island, 4 island GB)
//   video_data - 8 bits per channel, channel k at [8k+7:8k]
//   ctrl       - {c1,c0} per channel, channel k at [2k+1:2k]
//   aux        - TERC4 nibble per channel, channel k at [4k+3:4k]
//   tmds       - 10-bit symbol per channel, channel k at [10k+9:10k], bit 0 first
module tmds_channel_encoder #(
    parameter int CHANNELS = 3
) (
    input  logic                   clkin,
    input  logic                   rstin,
    input  logic                   ce,
    input  logic [2:0]             mode,
    input  logic [8*CHANNELS-1:0]  video_data,
    input  logic [2*CHANNELS-1:0]  ctrl,
    input  logic [4*CHANNELS-1:0]  aux,
    output logic [10*CHANNELS-1:0] tmds
);

    localparam logic [2:0] MODE_CTRL  = 3'd0;
    localparam logic [2:0] MODE_VIDEO = 3'd1;
    localparam logic [2:0] MODE_VGB   = 3'd2;
    localparam logic [2:0] MODE_DI    = 3'd3;
    localparam logic [2:0] MODE_DIGB  = 3'd4;

    localparam logic [9:0] SYM_CTRL00 = 10'b1101010100;
    localparam logic [9:0] SYM_GB_A   = 10'b1011001100;
    localparam logic [9:0] SYM_GB_B   = 10'b0100110011;

    function automatic logic [3:0] f_ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] f_ctrl(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] f_terc4(input logic [3:0] n);
        logic [9:0] s;
        case (n)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000111;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Stage-1 mode is shared by every channel.
    logic [2:0] r_mode;
    logic       w_is_video;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            r_mode <= MODE_CTRL;
        end else if (ce) begin
            r_mode <= mode;
        end
    end

    assign w_is_video = (r_mode == MODE_VIDEO);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam int ROLE = k % 3;

        logic [7:0]        w_d;
        logic [3:0]        w_n1;
        logic              w_xnor;
        logic [8:0]        w_qm;
        logic [1:0]        r_ctrl;
        logic [3:0]        r_aux;
        logic [8:0]        r_qm;
        logic [3:0]        w_n1q;
        logic signed [5:0] w_diff;
        logic signed [5:0] w_cnt_nxt;
        logic signed [5:0] r_cnt;
        logic [9:0]        w_vid;
        logic [9:0]        w_sym;
        logic [9:0]        r_sym;

        assign w_d = video_data[8*k +: 8];

        // Transition-minimising stage: XNOR chain when ones dominate.
        always_comb begin
            w_n1   = f_ones8(w_d);
            w_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !w_d[0]);
            w_qm   = '0;
            w_qm[0] = w_d[0];
            for (int i = 1; i < 8; i++) begin
                w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ w_d[i])
                                 :  (w_qm[i-1] ^ w_d[i]);
            end
            w_qm[8] = ~w_xnor;
        end

        always_ff @(posedge clkin or posedge rstin) begin
            if (rstin) begin
                r_ctrl <= 2'b00;
                r_aux  <= 4'h0;
                r_qm   <= 9'd0;
            end else if (ce) begin
                r_ctrl <= ctrl[2*k +: 2];
                r_aux  <= aux[4*k +: 4];
                r_qm   <= w_qm;
            end
        end

        // DC-balance stage. w_diff is N1q-N0q = 2*N1q-8.
        always_comb begin
            w_n1q  = f_ones8(r_qm[7:0]);
            w_diff = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;
            if ((r_cnt == 6'sd0) || (w_diff == 6'sd0)) begin
                w_vid = {~r_qm[8], r_qm[8],
                         r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff)
                                    : (r_cnt - w_diff);
            end else if (((r_cnt > 6'sd0) && (w_diff > 6'sd0)) ||
                         ((r_cnt < 6'sd0) && (w_diff < 6'sd0))) begin
                w_vid     = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt_nxt = r_cnt - w_diff
                          + (r_qm[8] ? 6'sd2 : 6'sd0);
            end else begin
                w_vid     = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt_nxt = r_cnt + w_diff
                          - (r_qm[8] ? 6'sd0 : 6'sd2);
            end
        end

        // Codes 5-7 fall through to control.
        always_comb begin
            case (r_mode)
                MODE_VIDEO: w_sym = w_vid;
                MODE_VGB:   w_sym = (ROLE == 1) ? SYM_GB_B : SYM_GB_A;
                MODE_DI:    w_sym = f_terc4(r_aux);
                MODE_DIGB:  w_sym = (ROLE == 0) ? f_terc4(r_aux) : SYM_GB_B;
                default:    w_sym = f_ctrl(r_ctrl);
            endcase
        end

        // Disparity never survives a non-video period.
        always_ff @(posedge clkin or posedge rstin) begin
            if (rstin) begin
                r_sym <= SYM_CTRL00;
                r_cnt <= 6'sd0;
            end else if (ce) begin
                r_sym <= w_sym;
                r_cnt <= w_is_video ? w_cnt_nxt : 6'sd0;
            end
        end

        assign tmds[10*k +: 10] = r_sym;
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: directed and randomised checks of the TMDS encoder
// against a behavioural symbol model plus an independent DVI decoder.
module tb_tmds_channel_encoder;

    localparam int CH = 3;

    localparam logic [9:0] CTRL00 = 10'b1101010100;
    localparam logic [9:0] CTRL01 = 10'b0010101011;
    localparam logic [9:0] GB_A   = 10'b1011001100;
    localparam logic [9:0] GB_B   = 10'b0100110011;

    logic              clkin = 1'b0;
    logic              rstin;
    logic              ce;
    logic [2:0]        mode;
    logic [8*CH-1:0]   video_data;
    logic [2*CH-1:0]   ctrl;
    logic [4*CH-1:0]   aux;
    logic [10*CH-1:0]  tmds;

    tmds_channel_encoder #(.CHANNELS(CH)) dut (
        .clkin      (clkin),
        .rstin      (rstin),
        .ce         (ce),
        .mode       (mode),
        .video_data (video_data),
        .ctrl       (ctrl),
        .aux        (aux),
        .tmds       (tmds)
    );

    always #5 clkin = ~clkin;

    int checks   = 0;
    int failures = 0;

    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    logic [9:0] ctrl_tab [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    // Model state: per-channel running disparity and a two-deep pipeline.
    int              mcnt [CH];
    int              rd   [CH];
    logic [10*CH-1:0] exp_pend, exp_cur;
    logic [8*CH-1:0]  dat_pend, dat_cur;
    bit               vid_pend, vid_cur;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model_video(input int k, input logic [7:0] d);
        int         n1, n1q, n0q, qq;
        bit         use_xnor;
        logic [8:0] q;
        logic [9:0] s;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !use_xnor;
        qq  = q[8] ? 1 : 0;
        n1q = $countones(q[7:0]);
        n0q = 8 - n1q;
        if (mcnt[k] == 0 || n1q == n0q) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            mcnt[k] = mcnt[k] + (qq == 1 ? n1q - n0q : n0q - n1q);
        end else if ((mcnt[k] > 0 && n1q > n0q) ||
                     (mcnt[k] < 0 && n0q > n1q)) begin
            s = {1'b1, q[8], ~q[7:0]};
            mcnt[k] = mcnt[k] + 2 * qq + n0q - n1q;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            mcnt[k] = mcnt[k] - 2 * (1 - qq) + n1q - n0q;
        end
        return s;
    endfunction

    function automatic logic [10*CH-1:0] model_cycle(
        input logic [2:0] m, input logic [8*CH-1:0] vd,
        input logic [2*CH-1:0] ct, input logic [4*CH-1:0] ax);
        logic [10*CH-1:0] r;
        int               mm;
        r  = '0;
        mm = (m > 3'd4) ? 0 : int'(m);
        for (int k = 0; k < CH; k++) begin
            if (mm == 1) begin
                r[10*k +: 10] = model_video(k, vd[8*k +: 8]);
            end else begin
                mcnt[k] = 0;
                case (mm)
                    2: r[10*k +: 10] = (k % 3 == 1) ? GB_B : GB_A;
                    3: r[10*k +: 10] = terc4_tab[ax[4*k +: 4]];
                    4: r[10*k +: 10] = (k % 3 == 0) ? terc4_tab[ax[4*k +: 4]]
                                                    : GB_B;
                    default: r[10*k +: 10] = ctrl_tab[ct[2*k +: 2]];
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] dvi_decode(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            mcnt[k] = 0;
            rd[k]   = 0;
        end
        exp_pend = {CH{CTRL00}};
        exp_cur  = {CH{CTRL00}};
        dat_pend = '0;
        dat_cur  = '0;
        vid_pend = 1'b0;
        vid_cur  = 1'b0;
    endtask

    task automatic step(input bit en, input logic [2:0] m,
                        input logic [8*CH-1:0] vd,
                        input logic [2*CH-1:0] ct,
                        input logic [4*CH-1:0] ax);
        logic [9:0] s;
        int         dsp;
        @(negedge clkin);
        ce = en;
        mode = m;
        video_data = vd;
        ctrl = ct;
        aux = ax;
        @(posedge clkin);
        #1;
        if (en) begin
            exp_cur  = exp_pend;
            dat_cur  = dat_pend;
            vid_cur  = vid_pend;
            exp_pend = model_cycle(m, vd, ct, ax);
            dat_pend = vd;
            vid_pend = (m == 3'd1);
        end
        chk("tmds", 32'(tmds), 32'(exp_cur));
        if (en) begin
            for (int k = 0; k < CH; k++) begin
                if (vid_cur) begin
                    s = tmds[10*k +: 10];
                    chk("decode", 32'(dvi_decode(s)), 32'(dat_cur[8*k +: 8]));
                    dsp = 2 * $countones(s) - 10;
                    rd[k] = rd[k] + dsp;
                    chk("rd_bound", 32'(rd[k] >= -10 && rd[k] <= 10), 32'd1);
                end else begin
                    rd[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [8*CH-1:0] rvd();
        return (8*CH)'($urandom());
    endfunction

    function automatic logic [2*CH-1:0] rct();
        return (2*CH)'($urandom());
    endfunction

    function automatic logic [4*CH-1:0] rax();
        return (4*CH)'($urandom());
    endfunction

    logic [2:0] rm;
    logic [3:0] nib;

    initial begin
        rstin = 1'b1;
        ce = 1'b0;
        mode = 3'd0;
        video_data = '0;
        ctrl = '0;
        aux = '0;
        model_reset();
        #22;
        chk("reset_state", 32'(tmds), 32'({CH{CTRL00}}));
        @(negedge clkin);
        rstin = 1'b0;

        step(1'b1, 3'd0, '0, {CH{2'b01}}, '0);
        chk("release_1", 32'(tmds), 32'({CH{CTRL00}}));
        step(1'b1, 3'd0, '0, {CH{2'b01}}, '0);
        chk("release_2", 32'(tmds), 32'({CH{CTRL01}}));

        // DC balance on a run of zero bytes from cnt 0.
        step(1'b1, 3'd1, '0, '0, '0);
        step(1'b1, 3'd1, '0, '0, '0);
        chk("dc0", 32'(tmds[9:0]), 32'h100);
        step(1'b1, 3'd1, '0, '0, '0);
        chk("dc1", 32'(tmds[9:0]), 32'h3FF);
        step(1'b1, 3'd0, '0, '0, '0);
        chk("dc2", 32'(tmds[9:0]), 32'h100);
        step(1'b1, 3'd0, '0, '0, '0);

        // Guard bands.
        step(1'b1, 3'd2, rvd(), rct(), rax());
        step(1'b1, 3'd0, '0, '0, '0);
        chk("vgb", 32'(tmds), 32'({GB_A, GB_B, GB_A}));
        step(1'b1, 3'd4, rvd(), rct(), {8'($urandom()), 4'hC});
        step(1'b1, 3'd0, '0, '0, '0);
        chk("digb", 32'(tmds), 32'({GB_B, GB_B, 10'b1010001110}));

        // TERC4 sweep.
        for (int n = 0; n <= 16; n++) begin
            nib = 4'(n);
            step(1'b1, (n < 16) ? 3'd3 : 3'd0, rvd(), '0, {CH{nib}});
            if (n >= 1)
                chk("terc4", 32'(tmds), 32'({CH{terc4_tab[n-1]}}));
        end

        // Long video run with random inserted non-video cycles.
        for (int i = 0; i < 3000; i++) begin
            rm = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            step(1'b1, rm, rvd(), rct(), rax());
        end

        // Reset mid-video: symbols fall to control 00 immediately.
        step(1'b1, 3'd1, rvd(), rct(), rax());
        step(1'b1, 3'd1, rvd(), rct(), rax());
        #1;
        rstin = 1'b1;
        #1;
        chk("rst_async", 32'(tmds), 32'({CH{CTRL00}}));
        @(negedge clkin);
        ce = 1'b0;
        model_reset();
        @(negedge clkin);
        rstin = 1'b0;
        for (int i = 0; i < 6; i++)
            step(1'b1, 3'd1, rvd(), rct(), rax());

        // Random clock-enable stalls during video.
        for (int i = 0; i < 3000; i++) begin
            rm = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            step(1'($urandom_range(0, 1)), rm, rvd(), rct(), rax());
        end

        step(1'b1, 3'd0, '0, '0, '0);
        step(1'b1, 3'd0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
